bitscan_prio_encoder: RTL and testbench

- Registered lowest-set-bit detector for a WIDTH-bit request vector.
- Produces a one-hot mask of the winning bit (bitscan function), its binary index (priority-encoder function) and a valid flag.
- Serves as the voice/slot allocator front end in the synth datapath. Used wherever a free or active line must be picked from up to 128 candidates.

---
 rtl/bitscan_pkg.sv | 20 ++
 rtl/bitscan_prio_encoder_if.sv | 22 ++
 rtl/onehot_to_bin.sv | 29 ++
 rtl/bitscan_prio_encoder.sv | 60 ++++++
 tb/tb_bitscan_prio_encoder.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/bitscan_pkg.sv
// Shared definitions for the lowest-set-bit detector.
// - DefaultWidth : default request vector width
// - MaxWidth     : widest vector lsb_isolate() can handle (callers zero-extend into it)
// - idx_width()  : binary index width for a given request width
// - lsb_isolate(): vec & -vec, isolates the lowest set bit
package bitscan_pkg;

  localparam int unsigned DefaultWidth = 128;
  localparam int unsigned MaxWidth     = 4096;

  function automatic int unsigned idx_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  // Zero-extension is safe: the low bits of -vec do not depend on the width of the negate.
  function automatic logic [MaxWidth-1:0] lsb_isolate(input logic [MaxWidth-1:0] vec);
    return vec & (~vec + MaxWidth'(1));
  endfunction

endpackage

// File: rtl/bitscan_prio_encoder_if.sv
// Request/result bundle of the lowest-set-bit detector.
// - in     : request vector, bit 0 = highest priority
// - onehot : registered one-hot mask of the winner
// - idx    : registered binary index of the winner
// - valid  : registered, high when the sampled request vector was non-zero
// master drives requests; slave (the encoder) drives results.
interface bitscan_prio_encoder_if
  import bitscan_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned IDX_W = idx_width(WIDTH)
);

  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] onehot;
  logic [IDX_W-1:0] idx;
  logic             valid;

  modport master (output in, input onehot, input idx, input valid);
  modport slave  (input in, output onehot, output idx, output valid);

endinterface

// File: rtl/onehot_to_bin.sv
// Purely combinational one-hot to binary encoder built as an OR-tree.
// - onehot : WIDTH-bit vector with at most one bit set
// - bin    : index of the set bit (0 when onehot is zero)
// Each output bit is the OR of the input lines whose index has that bit set, so there is
// no priority chain. Index values >= WIDTH simply have no inputs (tied to 0).
module onehot_to_bin #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned IDX_W = 7
) (
  input  logic [WIDTH-1:0] onehot,
  output logic [IDX_W-1:0] bin
);

  always_comb begin
    bin = '0;
    for (int k = 0; k < IDX_W; k++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (((i >> k) & 1) == 1) begin
          bin[k] = bin[k] | onehot[i];
        end
      end
    end
  end

  // Line 0 encodes to index 0 and so feeds no tree output.
  logic unused_line0;
  assign unused_line0 = onehot[0];

endmodule

// File: rtl/bitscan_prio_encoder.sv
// Registered lowest-set-bit detector (bitscan + priority encoder), one clock of latency.
// - clk : system clock, all state on rising edge
// - rst : synchronous active-high reset, clears all outputs
// - bus : slave side of bitscan_prio_encoder_if (in -> onehot/idx/valid)
// The only state is the output register stage; in is sampled every cycle.
// WIDTH must be in [2, MaxWidth).
module bitscan_prio_encoder
  import bitscan_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  localparam int unsigned IDX_W = idx_width(WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  bitscan_prio_encoder_if.slave  bus
);

  logic [MaxWidth-1:0] in_ext;
  logic [MaxWidth-1:0] win_ext;
  logic [WIDTH-1:0]    onehot_d, onehot_q;
  logic [IDX_W-1:0]    idx_d, idx_q;
  logic                valid_d, valid_q;

  always_comb begin
    in_ext              = '0;
    in_ext[WIDTH-1:0]   = bus.in;
    win_ext             = lsb_isolate(in_ext);
    onehot_d            = win_ext[WIDTH-1:0];
    valid_d             = |bus.in;
  end

  // Bits above WIDTH are always zero after isolation of a zero-extended vector.
  logic unused_win_hi;
  assign unused_win_hi = ^win_ext[MaxWidth-1:WIDTH];

  onehot_to_bin #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_onehot_to_bin (
    .onehot (onehot_d),
    .bin    (idx_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      onehot_q <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      onehot_q <= onehot_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.onehot = onehot_q;
  assign bus.idx    = idx_q;
  assign bus.valid  = valid_q;

endmodule

// File: tb/tb_bitscan_prio_encoder.sv
// Self-checking bench for bitscan_prio_encoder at the default 128-line width.
module tb_bitscan_prio_encoder;

  localparam int W  = 128;
  localparam int IW = 7;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  bitscan_prio_encoder_if #(.WIDTH(W)) bus ();

  bitscan_prio_encoder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs on the falling edge, then sample 1 time unit after the next rising edge.
  task automatic apply(input logic [W-1:0] v, input logic r);
    @(negedge clk);
    bus.in = v;
    rst    = r;
    @(posedge clk);
    #1;
  endtask

  // Reference: scan upward for the first set bit.
  task automatic model(input logic [W-1:0] v, output logic [W-1:0] oh,
                       output logic [IW-1:0] ix, output logic vl);
    oh = '0;
    ix = '0;
    vl = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (v[i] && !vl) begin
        vl    = 1'b1;
        oh[i] = 1'b1;
        ix    = IW'(i);
      end
    end
  endtask

  task automatic test_reset();
    logic [W-1:0] v;
    v = {$urandom, $urandom, $urandom, $urandom} | W'(1);
    apply(v, 1'b1);
    apply(v, 1'b1);
    checks++;
    if (bus.onehot !== '0 || bus.idx !== '0 || bus.valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: onehot=%h idx=%0d valid=%b, required all zero",
               bus.onehot, bus.idx, bus.valid);
    end
    for (int c = 0; c < 10; c++) begin
      apply('0, 1'b0);
      checks++;
      if (bus.onehot !== '0 || bus.idx !== '0 || bus.valid !== 1'b0) begin
        failures++;
        $display("FAIL zero_in cycle %0d: onehot=%h idx=%0d valid=%b, required all zero",
                 c, bus.onehot, bus.idx, bus.valid);
      end
    end
  endtask

  task automatic test_walking_one();
    logic [W-1:0] v;
    logic [W-1:0] e_oh;
    for (int i = 0; i < W; i++) begin
      v = '0;
      v[i] = 1'b1;
      apply(v, 1'b0);
      e_oh = '0;
      e_oh[i] = 1'b1;
      checks++;
      if (bus.onehot !== e_oh || bus.idx !== IW'(i) || bus.valid !== 1'b1) begin
        failures++;
        $display("FAIL walk bit %0d: onehot=%h idx=%0d valid=%b, required onehot=%h idx=%0d valid=1",
                 i, bus.onehot, bus.idx, bus.valid, e_oh, i);
      end
    end
    apply('0, 1'b0);
    checks++;
    if (bus.onehot !== '0 || bus.idx !== '0 || bus.valid !== 1'b0) begin
      failures++;
      $display("FAIL walk_shift_out: onehot=%h idx=%0d valid=%b, required all zero",
               bus.onehot, bus.idx, bus.valid);
    end
  endtask

  task automatic test_multi_bit();
    logic [W-1:0] v;
    v = '0;
    v[127] = 1'b1;
    v[2]   = 1'b1;
    v[1]   = 1'b1;
    apply(v, 1'b0);
    checks++;
    if (bus.onehot !== W'(2) || bus.idx !== IW'(1) || bus.valid !== 1'b1) begin
      failures++;
      $display("FAIL multi_bit_0x8..06: onehot=%h idx=%0d valid=%b, required onehot=2 idx=1 valid=1",
               bus.onehot, bus.idx, bus.valid);
    end
    v = '1;
    apply(v, 1'b0);
    checks++;
    if (bus.onehot !== W'(1) || bus.idx !== IW'(0) || bus.valid !== 1'b1) begin
      failures++;
      $display("FAIL all_ones: onehot=%h idx=%0d valid=%b, required onehot=1 idx=0 valid=1",
               bus.onehot, bus.idx, bus.valid);
    end
  endtask

  task automatic test_top_bit();
    logic [W-1:0] v;
    v = '0;
    v[W-1] = 1'b1;
    apply(v, 1'b0);
    checks++;
    if (bus.onehot !== v || bus.idx !== 7'h7F || bus.valid !== 1'b1) begin
      failures++;
      $display("FAIL top_bit: onehot=%h idx=%0d valid=%b, required onehot=%h idx=127 valid=1",
               bus.onehot, bus.idx, bus.valid, v);
    end
  endtask

  task automatic test_reset_mid_stream();
    logic [W-1:0] v;
    v = W'(32'h10);
    apply(v, 1'b0);
    apply(v, 1'b1);
    checks++;
    if (bus.onehot !== '0 || bus.idx !== '0 || bus.valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_edge: onehot=%h idx=%0d valid=%b, required all zero",
               bus.onehot, bus.idx, bus.valid);
    end
    apply(v, 1'b0);
    checks++;
    if (bus.onehot !== v || bus.idx !== IW'(4) || bus.valid !== 1'b1) begin
      failures++;
      $display("FAIL after_reset: onehot=%h idx=%0d valid=%b, required onehot=10 idx=4 valid=1",
               bus.onehot, bus.idx, bus.valid);
    end
  endtask

  task automatic test_random();
    logic [W-1:0]  v;
    logic [W-1:0]  e_oh;
    logic [IW-1:0] e_ix;
    logic          e_vl;
    int            kind;
    for (int n = 0; n < 12000; n++) begin
      kind = int'($urandom_range(0, 3));
      if (kind == 0) begin
        v = '0;
      end else if (kind == 1) begin
        v = '0;
        for (int b = 0; b < int'($urandom_range(1, 3)); b++) v[$urandom_range(0, W - 1)] = 1'b1;
      end else begin
        v = {$urandom, $urandom, $urandom, $urandom};
        // Thin the low bits sometimes so winners land across the whole range.
        if (kind == 3) v = v & ({W{1'b1}} << $urandom_range(0, W - 1));
      end
      apply(v, 1'b0);
      model(v, e_oh, e_ix, e_vl);
      checks++;
      if (bus.onehot !== e_oh || bus.idx !== e_ix || bus.valid !== e_vl) begin
        failures++;
        $display("FAIL random %0d in=%h: onehot=%h idx=%0d valid=%b, required onehot=%h idx=%0d valid=%b",
                 n, v, bus.onehot, bus.idx, bus.valid, e_oh, e_ix, e_vl);
      end
      checks++;
      if (bus.valid !== (|bus.onehot) ||
          (bus.valid === 1'b1 && bus.onehot !== (W'(1) << bus.idx))) begin
        failures++;
        $display("FAIL invariant %0d: onehot=%h idx=%0d valid=%b, required valid==|onehot and onehot==1<<idx",
                 n, bus.onehot, bus.idx, bus.valid);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.in   = '0;
    test_reset();
    test_walking_one();
    test_multi_bit();
    test_top_bit();
    test_reset_mid_stream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
